// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encodings, grant ids and wait-cycle bounds for mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_LDR = 1'b1
    } gnt_t;

    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;

    // Counter preload for a given wait length; out-of-range values are clamped.
    function automatic logic [3:0] wait_load(input int w);
        return (w < WAIT_MIN) ? 4'd0 : (w > WAIT_MAX) ? 4'd14 : 4'(w - 1);
    endfunction

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// mem_arb_wait_cnt: 4-bit loadable down-counter with zero flag, sync active-low reset.
module mem_arb_wait_cnt
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= 4'd0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU/loader arbiter and fixed-wait access sequencer for the shared memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    state_t        state, state_nxt;
    gnt_t          gnt, last_gnt, win;
    logic          any_req, cnt_zero, we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    assign any_req = cpu_req | ldr_req;
    // On a tie the CPU loses only in round-robin mode after it won last time.
    assign win = (cpu_req && !(RR_EN && ldr_req && last_gnt == GNT_CPU)) ? GNT_CPU : GNT_LDR;

    mem_arb_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == IDLE && any_req),
        .dec      (state == ACCESS),
        .load_val (wait_load(WAIT_CYCLES)),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = any_req ? ACCESS : IDLE;
            ACCESS:  state_nxt = cnt_zero ? DONE : ACCESS;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt      <= GNT_CPU;
            last_gnt <= GNT_LDR;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                gnt     <= win;
                we_q    <= (win == GNT_CPU) ? cpu_we : ldr_we;
                addr_q  <= (win == GNT_CPU) ? cpu_addr : ldr_addr;
                wdata_q <= (win == GNT_CPU) ? cpu_wdata : ldr_wdata;
            end
            if (state == ACCESS && cnt_zero && !we_q)
                rdata <= mem_rdata;
            if (state == DONE)
                last_gnt <= gnt;
        end
    end

    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign cpu_ack   = (state == DONE) && (gnt == GNT_CPU);
    assign ldr_ack   = (state == DONE) && (gnt == GNT_LDR);

endmodule
